m65c02_bus_wait_ctrl: RTL

//  External bus cycle responder for the M65C02A. Consumes the mapped PA/CE/Int_WS from the MMU,

---
 rtl/m65c02_bus_wait_ctrl_if.sv | 27 ++
 rtl/m65c02_bus_wait_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/m65c02_bus_wait_ctrl_if.sv
// Bus bundle between the M65C02A core/MMU side and the external bus wait-state responder.
// The master drives the mapped access; the slave returns strobes, data and Rdy.
interface m65c02_bus_wait_ctrl_if;
  logic [1:0]  IO_Op;
  logic [19:0] PA;
  logic [14:0] CE;
  logic        Int_WS;
  logic        Ext_WS;
  logic [7:0]  XDI;
  logic        Rdy;
  logic [19:0] XA;
  logic [14:0] nCE;
  logic        nOE;
  logic        nWE;
  logic [7:0]  DO;
  logic        Bus_Err;

  modport master (
    output IO_Op, PA, CE, Int_WS, Ext_WS, XDI,
    input  Rdy, XA, nCE, nOE, nWE, DO, Bus_Err
  );

  modport slave (
    input  IO_Op, PA, CE, Int_WS, Ext_WS, XDI,
    output Rdy, XA, nCE, nOE, nWE, DO, Bus_Err
  );
endinterface

// File: rtl/m65c02_bus_wait_ctrl.sv
// External bus cycle responder: drives SRAM/ROM/IO strobes and the core Rdy, inserting
// internal wait states, honouring external stretch requests, and timing out stuck cycles.
module m65c02_bus_wait_ctrl #(
  parameter int pWS_Out = 2,
  parameter int pCnt_W  = 4,
  parameter int pTO     = 255,
  parameter int pTO_W   = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  m65c02_bus_wait_ctrl_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [pCnt_W-1:0] WS_INIT = pCnt_W'(pWS_Out - 1);
  localparam logic [pTO_W-1:0]  TO_LAST = pTO_W'(pTO - 1);

  state_t             state, state_nxt;
  logic [pCnt_W-1:0]  cnt, cnt_nxt;
  logic [pTO_W-1:0]   to_cnt, to_nxt;

  logic op_active;
  logic ce_any;
  logic start;
  logic bus_act;
  logic cnt_done;
  logic to_last;

  assign op_active = (bus.IO_Op != 2'b00);
  assign ce_any    = |bus.CE;
  assign start     = Rst & op_active & ce_any & (bus.Int_WS | bus.Ext_WS) & (state == ST_IDLE);
  assign bus_act   = Rst & op_active & ce_any;
  assign cnt_done  = (cnt == '0);
  assign to_last   = (to_cnt == TO_LAST);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      to_cnt <= to_nxt;
    end
  end

  // Internal wait count runs first; Ext_WS only matters once it has expired.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    to_nxt    = to_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = bus.Int_WS ? WS_INIT : '0;
          to_nxt    = '0;
        end
      end
      ST_WAIT: begin
        if (!cnt_done) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!bus.Ext_WS || to_last) begin
          state_nxt = ST_IDLE;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.Rdy = Rst & (((state == ST_IDLE) & ~start) |
                          ((state == ST_WAIT) & cnt_done & (~bus.Ext_WS | to_last)));

  // Error flag coincides with the forced-completion Rdy so the core sees both together.
  assign bus.Bus_Err = Rst & (state == ST_WAIT) & cnt_done & bus.Ext_WS & to_last;

  assign bus.XA  = bus_act ? bus.PA : '0;
  assign bus.nCE = ~(bus.CE & {15{bus_act}});
  assign bus.nOE = ~(bus_act & bus.IO_Op[1]);
  assign bus.nWE = ~(bus_act & (bus.IO_Op == 2'b01));
  assign bus.DO  = (bus_act & bus.IO_Op[1]) ? bus.XDI : '0;

endmodule
